// File: rtl/dark_count_run_controller.sv
// Dark-count run controller: clears the pulse counter, opens a fixed-length
// gate, latches the count and overflow flag, then streams a 6-byte result frame
// (header, count MSB..LSB, overflow) to the UART transmitter.
module dark_count_run_controller #(
   parameter int unsigned GATE_CYCLES = 100_000_000,
   parameter int unsigned COUNT_WIDTH = 32,
   parameter logic [7:0]  CMD_START   = 8'h53,
   parameter logic [7:0]  CMD_ABORT   = 8'h58,
   parameter logic [7:0]  HEADER      = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst_button,
   input  logic                   start_button,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   cnt_clear,
   output logic                   cnt_enable,
   input  logic [COUNT_WIDTH-1:0] cnt_value,
   input  logic                   cnt_overflow,
   output logic                   busy,
   output logic                   gate_led
);

   localparam int unsigned TIMER_W = $clog2(GATE_CYCLES) + 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
   localparam logic [2:0] LAST_IDX = 3'd5;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      GATE,
      LATCH,
      SEND
   } state_t;

   state_t                 state;
   logic [TIMER_W-1:0]     gate_timer;
   logic [COUNT_WIDTH-1:0] count_latched;
   logic                   overflow_latched;
   logic [2:0]             idx;
   logic                   abort_pending;

   logic start_event;
   logic abort_event;
   logic accept;

   assign start_event = start_button | (rx_valid && (rx_data == CMD_START));
   assign abort_event = rx_valid && (rx_data == CMD_ABORT);
   assign accept      = tx_valid & tx_ready;
   // The LED mirrors the registered gate enable, so it needs no register of its own.
   assign gate_led    = cnt_enable;

   // Frame byte for a given index; the overflow flag rides in the last byte.
   function automatic logic [7:0] frame_byte(input logic [2:0] i,
                                             input logic [COUNT_WIDTH-1:0] c,
                                             input logic o);
      case (i)
         3'd0:    frame_byte = HEADER;
         3'd1:    frame_byte = c[31:24];
         3'd2:    frame_byte = c[23:16];
         3'd3:    frame_byte = c[15:8];
         3'd4:    frame_byte = c[7:0];
         3'd5:    frame_byte = {7'b0, o};
         default: frame_byte = 8'h00;
      endcase
   endfunction

   // Run sequencer with all outputs registered; tx_valid never looks at tx_ready combinationally.
   always_ff @(posedge clk or negedge rst_button) begin
      if (!rst_button) begin
         state            <= IDLE;
         gate_timer       <= '0;
         count_latched    <= '0;
         overflow_latched <= 1'b0;
         idx              <= 3'd0;
         abort_pending    <= 1'b0;
         tx_data          <= 8'h00;
         tx_valid         <= 1'b0;
         cnt_clear        <= 1'b0;
         cnt_enable       <= 1'b0;
         busy             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_event) begin
                  state     <= CLEAR;
                  cnt_clear <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            CLEAR: begin
               cnt_clear  <= 1'b0;
               gate_timer <= '0;
               if (abort_event) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state      <= GATE;
                  cnt_enable <= 1'b1;
               end
            end
            GATE: begin
               gate_timer <= gate_timer + 1'b1;
               if (abort_event) begin
                  state      <= IDLE;
                  cnt_enable <= 1'b0;
                  busy       <= 1'b0;
               end else if (gate_timer == TIMER_LAST) begin
                  state      <= LATCH;
                  cnt_enable <= 1'b0;
               end
            end
            LATCH: begin
               // The counter has been frozen for one cycle, so its value is final here.
               if (abort_event) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  count_latched    <= cnt_value;
                  overflow_latched <= cnt_overflow;
                  idx              <= 3'd0;
                  abort_pending    <= 1'b0;
                  tx_data          <= HEADER;
                  tx_valid         <= 1'b1;
                  state            <= SEND;
               end
            end
            SEND: begin
               // An abort lets the byte already on offer complete before stopping.
               if (abort_event) begin
                  abort_pending <= 1'b1;
               end
               if (accept) begin
                  if ((idx == LAST_IDX) || abort_pending || abort_event) begin
                     state         <= IDLE;
                     tx_valid      <= 1'b0;
                     tx_data       <= 8'h00;
                     busy          <= 1'b0;
                     idx           <= 3'd0;
                     abort_pending <= 1'b0;
                  end else begin
                     idx     <= idx + 3'd1;
                     tx_data <= frame_byte(idx + 3'd1, count_latched, overflow_latched);
                  end
               end
            end
            default: begin
               state      <= IDLE;
               tx_valid   <= 1'b0;
               cnt_clear  <= 1'b0;
               cnt_enable <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dark_count_run_controller.sv
// Bench for the dark-count run controller: a saturating counter model feeds
// cnt_value, a ready generator shapes tx_ready, and a byte scoreboard checks
// every frame the controller emits.
module tb_dark_count_run_controller;

   localparam int unsigned GATE = 1000;

   logic        clk = 1'b0;
   logic        rst_button = 1'b1;
   logic        start_button = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        cnt_clear;
   logic        cnt_enable;
   logic [31:0] cnt_value = 32'h0;
   logic        cnt_overflow = 1'b0;
   logic        busy;
   logic        gate_led;

   int tests = 0;
   int fails = 0;

   dark_count_run_controller #(.GATE_CYCLES(GATE)) dut (
      .clk          (clk),
      .rst_button   (rst_button),
      .start_button (start_button),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .cnt_clear    (cnt_clear),
      .cnt_enable   (cnt_enable),
      .cnt_value    (cnt_value),
      .cnt_overflow (cnt_overflow),
      .busy         (busy),
      .gate_led     (gate_led)
   );

   always #5 clk = ~clk;

   // Counter model: 5 pulses/cycle for 660 cycles then 4/cycle gives 0x1234 over 1000 cycles.
   logic        sat_mode = 1'b0;
   int          gidx = 0;
   logic [31:0] pulses;
   logic [32:0] sum;
   assign pulses = sat_mode ? 32'h0100_0000 : ((gidx < 660) ? 32'd5 : 32'd4);
   assign sum    = {1'b0, cnt_value} + {1'b0, pulses};

   always @(posedge clk) begin
      if (cnt_clear) begin
         cnt_value    <= 32'h0;
         cnt_overflow <= 1'b0;
         gidx         <= 0;
      end else if (cnt_enable) begin
         gidx <= gidx + 1;
         if (sum[32]) begin
            cnt_value    <= 32'hFFFF_FFFF;
            cnt_overflow <= 1'b1;
         end else begin
            cnt_value <= sum[31:0];
         end
      end
   end

   // Monitor: captures accepted bytes and counts enable/clear/valid cycles and stall violations.
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int en_cnt = 0, clr_cnt = 0, txv_cnt = 0, stall_err = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(negedge clk) begin
      if (cnt_enable) en_cnt++;
      if (cnt_clear)  clr_cnt++;
      if (tx_valid)   txv_cnt++;
      if (prev_stall && !(tx_valid === 1'b1 && tx_data === prev_data)) stall_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
   end

   // Ready generator: 0 always ready, 1 ready one cycle in three, 2 never, 3 ready until limit bytes seen.
   int ready_mode = 0;
   int ready_limit = 100;
   int rcyc = 0;
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0: tx_ready = 1'b1;
            1: begin tx_ready = (rcyc % 3 == 0); rcyc++; end
            2: tx_ready = 1'b0;
            default: tx_ready = (rx_q.size() < ready_limit);
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic push_frame(input logic [31:0] c, input logic o);
      exp_q.push_back(8'hA5);
      exp_q.push_back(c[31:24]);
      exp_q.push_back(c[23:16]);
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[7:0]);
      exp_q.push_back({7'b0, o});
   endtask

   task automatic check_frame(input string tag);
      logic [7:0] e, o;
      int n;
      n = 0;
      chk({tag, "_len"}, rx_q.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
         chk($sformatf("%s_b%0d", tag, n), o, e);
         n++;
      end
      rx_q.delete();
   endtask

   task automatic drive_cycle(input logic sb, input logic rv, input logic [7:0] rd);
      @(posedge clk); #1;
      start_button = sb;
      rx_valid     = rv;
      rx_data      = rd;
      @(posedge clk); #1;
      start_button = 1'b0;
      rx_valid     = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_tx_valid"}, tx_valid, 1'b0);
      chk({tag, "_tx_data"}, tx_data, 8'h00);
      chk({tag, "_cnt_clear"}, cnt_clear, 1'b0);
      chk({tag, "_cnt_enable"}, cnt_enable, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_gate_led"}, gate_led, 1'b0);
   endtask

   int en0, clr0, txv0, st0;

   initial begin
      // Reset state
      #3 rst_button = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1 rst_button = 1'b1;
      repeat (3) @(posedge clk);

      // 1: start button, always ready
      ready_mode = 0; sat_mode = 1'b0; rx_q.delete();
      en0 = en_cnt; clr0 = clr_cnt;
      push_frame(32'h0000_1234, 1'b0);
      drive_cycle(1'b1, 1'b0, 8'h00);
      wait_idle("t1");
      chk("t1_bytes_at_busy_fall", rx_q.size(), 6);
      chk("t1_enable_cycles", en_cnt - en0, GATE);
      chk("t1_clear_cycles", clr_cnt - clr0, 1);
      check_frame("t1");
      $display("[TB] t1 start_button run done");

      // 2: RX 'S', ready one cycle in three
      ready_mode = 1; st0 = stall_err;
      push_frame(32'h0000_1234, 1'b0);
      drive_cycle(1'b0, 1'b1, 8'h53);
      wait_idle("t2");
      chk("t2_stall_stable", stall_err - st0, 0);
      check_frame("t2");
      $display("[TB] t2 rx start with stalls done");

      // 3: saturated counter
      ready_mode = 0; sat_mode = 1'b1;
      push_frame(32'hFFFF_FFFF, 1'b1);
      drive_cycle(1'b1, 1'b0, 8'h00);
      wait_idle("t3");
      check_frame("t3");
      sat_mode = 1'b0;
      $display("[TB] t3 saturated run done");

      // 4a: abort mid-gate
      txv0 = txv_cnt; en0 = en_cnt;
      drive_cycle(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cnt_enable) break;
      end
      chk("t4a_gate_open", cnt_enable, 1'b1);
      repeat (499) @(posedge clk);
      drive_cycle(1'b0, 1'b1, 8'h58);
      @(negedge clk);
      chk("t4a_enable_low", cnt_enable, 1'b0);
      chk("t4a_busy_low", busy, 1'b0);
      chk("t4a_short_gate", (en_cnt - en0) < GATE, 1'b1);
      repeat (1200) @(negedge clk);
      chk("t4a_no_tx", txv_cnt - txv0, 0);
      chk("t4a_no_bytes", rx_q.size(), 0);
      $display("[TB] t4a abort in gate done");

      // 4b: abort while byte 2 is stalled
      ready_mode = 3; ready_limit = 2;
      exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      drive_cycle(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (rx_q.size() == 2) break;
      end
      repeat (4) @(negedge clk);
      chk("t4b_stalled_valid", tx_valid, 1'b1);
      drive_cycle(1'b0, 1'b1, 8'h58);
      ready_mode = 0;
      repeat (10) @(negedge clk);
      chk("t4b_valid_low", tx_valid, 1'b0);
      chk("t4b_busy_low", busy, 1'b0);
      check_frame("t4b");
      $display("[TB] t4b abort in send done");

      // 5: simultaneous starts, then a start mid-gate is ignored
      en0 = en_cnt; clr0 = clr_cnt;
      push_frame(32'h0000_1234, 1'b0);
      drive_cycle(1'b1, 1'b1, 8'h53);
      repeat (300) @(posedge clk);
      drive_cycle(1'b0, 1'b1, 8'h53);
      wait_idle("t5");
      repeat (50) @(negedge clk);
      chk("t5_busy_after", busy, 1'b0);
      chk("t5_enable_cycles", en_cnt - en0, GATE);
      chk("t5_clear_cycles", clr_cnt - clr0, 1);
      check_frame("t5");
      $display("[TB] t5 single run done");

      // 6: reset during SEND idx 3
      ready_mode = 3; ready_limit = 3;
      exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      drive_cycle(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (rx_q.size() == 3) break;
      end
      repeat (3) @(negedge clk);
      chk("t6_stalled_valid", tx_valid, 1'b1);
      chk("t6_stalled_byte", tx_data, 8'h12);
      check_frame("t6_pre");
      #3 rst_button = 1'b0;
      #1 check_outputs_zero("t6_async");
      @(posedge clk); #1 rst_button = 1'b1; ready_mode = 0;
      txv0 = txv_cnt;
      repeat (50) @(negedge clk);
      chk("t6_no_tx_after", txv_cnt - txv0, 0);
      chk("t6_no_bytes_after", rx_q.size(), 0);
      push_frame(32'h0000_1234, 1'b0);
      drive_cycle(1'b0, 1'b1, 8'h53);
      wait_idle("t6_rerun");
      check_frame("t6_rerun");
      $display("[TB] t6 reset in send done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #2_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
